// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, data-memory waits, branch flush, halt.
// Optional stall-cycle counter enabled by defining PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             branch_taken,
    input  logic             wb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        DWAIT     = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t state, next;

    logic mem_op, lu_hazard;
    logic pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic ifid_f, idex_f, exmem_f, memwb_f;

    assign mem_op    = exmem_memread | exmem_memwrite;
    assign lu_hazard = idex_memread && (idex_rt != '0) &&
                       ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= next;
    end

    always_comb begin
        next    = state;
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        idex_w  = 1'b0;
        exmem_w = 1'b0;
        memwb_w = 1'b0;
        ifid_f  = 1'b0;
        idex_f  = 1'b0;
        exmem_f = 1'b0;
        memwb_f = 1'b0;
        case (state)
            HALTED: next = HALTED;
            default: begin
                if (wb_halt) begin
                    next = HALTED;
                end else if (mem_op && !dhit) begin
                    memwb_w = 1'b1;
                    memwb_f = 1'b1;
                    next    = DWAIT;
                end else if (branch_taken) begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = '1;
                    {ifid_f, idex_f, exmem_f} = '1;
                    next = RUN;
                end else if (lu_hazard && (state != LU_BUBBLE)) begin
                    // Hold PC and IF/ID, inject a NOP into ID/EX; masked in LU_BUBBLE so one bubble per pair.
                    {idex_w, exmem_w, memwb_w} = '1;
                    idex_f = 1'b1;
                    next   = LU_BUBBLE;
                end else if (!ihit) begin
                    {ifid_w, idex_w, exmem_w, memwb_w} = '1;
                    ifid_f = 1'b1;
                    next   = RUN;
                end else begin
                    {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = '1;
                    next = RUN;
                end
            end
        endcase
    end

    // Reset forces all controls low combinationally, not just at the next edge.
    assign pc_wen      = pc_w    & ~RST;
    assign ifid_wen    = ifid_w  & ~RST;
    assign idex_wen    = idex_w  & ~RST;
    assign exmem_wen   = exmem_w & ~RST;
    assign memwb_wen   = memwb_w & ~RST;
    assign ifid_flush  = ifid_f  & ~RST;
    assign idex_flush  = idex_f  & ~RST;
    assign exmem_flush = exmem_f & ~RST;
    assign memwb_flush = memwb_f & ~RST;
    assign halted      = (state == HALTED) & ~RST;
    assign state_o     = state;

`ifdef PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cycles <= '0;
        else if (!pc_wen && (state != HALTED) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: vector table from RUN plus multi-cycle sequences.
// Counter checks are included when PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0;
    logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic       idex_memread = 1'b0, exmem_memread = 1'b0, exmem_memwrite = 1'b0;
    logic       branch_taken = 1'b0, wb_halt = 1'b0;
    logic       pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [1:0] state_o;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad = 0;

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .branch_taken(branch_taken), .wb_halt(wb_halt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen),
        .exmem_wen(exmem_wen), .memwb_wen(memwb_wen),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halted(halted),
`ifdef PERF_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    logic [4:0] wen_v;
    logic [3:0] flush_v;
    assign wen_v   = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
    assign flush_v = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    typedef struct {
        logic       ihit, dhit;
        logic [4:0] rs, rt;
        logic       idex_mr;
        logic [4:0] idex_rt;
        logic       ex_mr, ex_mw, br, halt;
        logic [4:0] wen;    // {pc, ifid, idex, exmem, memwb}
        logic [3:0] flush;  // {ifid, idex, exmem, memwb}
        logic [1:0] nxt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; ifid_rs = v.rs; ifid_rt = v.rt;
        idex_memread = v.idex_mr; idex_rt = v.idex_rt;
        exmem_memread = v.ex_mr; exmem_memwrite = v.ex_mw;
        branch_taken = v.br; wb_halt = v.halt;
    endtask

    task automatic clear_in();
        ihit = 1'b1; dhit = 1'b0; ifid_rs = '0; ifid_rt = '0;
        idex_memread = 1'b0; idex_rt = '0; exmem_memread = 1'b0;
        exmem_memwrite = 1'b0; branch_taken = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK); #1;
    endtask

    initial begin
        //             ihit dhit rs    rt    imr irt   emr emw br  hlt  wen       flush    nxt
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01111, 4'b1000, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 2'd1};
        vecs[3]  = '{1'b1, 1'b0, 5'd2, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 2'd1};
        vecs[4]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 4'b0000, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001, 4'b0001, 2'd2};
        vecs[7]  = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11111, 4'b0000, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 4'b1110, 2'd0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00001, 4'b0001, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, 4'b0000, 2'd3};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 4'b1110, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11111, 4'b1110, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00111, 4'b0100, 2'd1};

        // Reset state while RST is high
        #2;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_wen", 32'(wen_v), 32'd0);
        check("rst_flush", 32'(flush_v), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        for (int i = 0; i < 14; i++) begin
            clear_in();
            do_reset();
            set_in(vecs[i]);
            #1;
            check($sformatf("v%0d_wen", i), 32'(wen_v), 32'(vecs[i].wen));
            check($sformatf("v%0d_flush", i), 32'(flush_v), 32'(vecs[i].flush));
            step();
            check($sformatf("v%0d_next", i), 32'(state_o), 32'(vecs[i].nxt));
        end

        // Load-use: exactly one bubble, then advance with the same hazard inputs
        clear_in(); do_reset();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; #1;
        check("lu_stall_wen", 32'(wen_v), 32'b00111);
        step();
        check("lu_state", 32'(state_o), 32'd1);
        check("lu_bubble_wen", 32'(wen_v), 32'b11111);
        check("lu_bubble_flush", 32'(flush_v), 32'd0);
        step();
        check("lu_back_run", 32'(state_o), 32'd0);

        // Data-memory wait: 3 stall cycles then dhit releases
        clear_in(); do_reset();
        exmem_memread = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("dw%0d_wen", c), 32'(wen_v), 32'b00001);
            check($sformatf("dw%0d_flush", c), 32'(flush_v), 32'b0001);
            step();
            check($sformatf("dw%0d_state", c), 32'(state_o), 32'd2);
        end
        dhit = 1'b1; #1;
        check("dw_hit_wen", 32'(wen_v), 32'b11111);
        step();
        check("dw_exit_state", 32'(state_o), 32'd0);

        // Asynchronous reset in the middle of DWAIT
        clear_in(); do_reset();
        exmem_memread = 1'b1; step();
        check("rdw_pre_state", 32'(state_o), 32'd2);
        #2; RST = 1'b1; #1;
        check("rdw_state", 32'(state_o), 32'd0);
        check("rdw_wen", 32'(wen_v), 32'd0);
        check("rdw_flush", 32'(flush_v), 32'd0);
        @(negedge CLK);
        exmem_memread = 1'b0; ihit = 1'b1; RST = 1'b0; #1;
        check("rdw_release_wen", 32'(wen_v), 32'b11111);

        // Asynchronous reset in the middle of LU_BUBBLE
        clear_in(); do_reset();
        idex_memread = 1'b1; idex_rt = 5'd3; ifid_rt = 5'd3; step();
        check("rlu_pre_state", 32'(state_o), 32'd1);
        #2; RST = 1'b1; #1;
        check("rlu_state", 32'(state_o), 32'd0);
        check("rlu_wen", 32'(wen_v), 32'd0);
        RST = 1'b0;

        // Halt is sticky regardless of handshakes
        clear_in(); do_reset();
        wb_halt = 1'b1; #1;
        check("halt_entry_wen", 32'(wen_v), 32'd0);
        check("halt_entry_halted", 32'(halted), 32'd0);
        step();
        wb_halt = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ihit = c[0]; dhit = ~c[0]; branch_taken = c[1]; exmem_memread = c[0]; #1;
            check($sformatf("halt%0d_halted", c), 32'(halted), 32'd1);
            check($sformatf("halt%0d_wen", c), 32'(wen_v), 32'd0);
            check($sformatf("halt%0d_flush", c), 32'(flush_v), 32'd0);
            check($sformatf("halt%0d_state", c), 32'(state_o), 32'd3);
            step();
        end

`ifdef PERF_CNT_EN
        clear_in(); do_reset();
        #1;
        check("perf_rst", stall_cycles, 32'd0);
        ihit = 1'b0;
        repeat (4) step();
        ihit = 1'b1; #1;
        check("perf_four", stall_cycles, 32'd4);
        wb_halt = 1'b1; step();
        wb_halt = 1'b0;
        check("perf_halt_entry", stall_cycles, 32'd5);
        repeat (3) step();
        check("perf_halted_hold", stall_cycles, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the WEN and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It reads back stage outputs (memory-op flags, register fields, branch resolution) and the cache handshakes ihit/dhit. A small FSM tracks multi-cycle data-memory waits, load-use bubbles and halt.

Parameters:
REG_W, 5, register-index width (rs/rt fields)
CNT_W, 32, width of stall counter (used only with PERF_CNT_EN)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
ihit  input  1  instruction fetch completes this cycle
dhit  input  1  data access completes this cycle
ifid_rs  input  REG_W  rs field of IF/ID instruction_out
ifid_rt  input  REG_W  rt field of IF/ID instruction_out
idex_memread  input  1  ID/EX M_MemRead_out
idex_rt  input  REG_W  ID/EX rt_out
exmem_memread  input  1  EX/MEM M_MemRead_out
exmem_memwrite  input  1  EX/MEM M_MemWrite_out
branch_taken  input  1  EX/MEM M_Branch_out & alu_zero_out
wb_halt  input  1  halt instruction present in MEM/WB
pc_wen  output  1  PC load enable
ifid_wen, idex_wen, exmem_wen, memwb_wen  output  1 each  register WEN
ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load NOP at next edge
halted  output  1  core halted
state_o  output  2  current FSM state (RUN=0, LU_BUBBLE=1, DWAIT=2, HALTED=3)

Behaviour:
- One clock (CLK); reset asynchronous, active-high (RST). While RST=1: state=RUN, all wen=0, all flush=0, halted=0, state_o=0.
- Outputs combinational from state + inputs (same-cycle response to ihit/dhit); state registered.
- Flush semantics: flush=1 with wen=1 loads NOP at the edge; wen=0 holds regardless of flush.
- mem_op = exmem_memread | exmem_memwrite. lu_hazard = idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- RUN / LU_BUBBLE / DWAIT: identical priority evaluation each cycle, highest first:
  1 wb_halt: all wen=0; next=HALTED.
  2 mem_op & !dhit: pc/ifid/idex/exmem wen=0; memwb_wen=1, memwb_flush=1; next=DWAIT.
  3 branch_taken: all wen=1; ifid_flush=idex_flush=exmem_flush=1; next=RUN.
  4 lu_hazard & state!=LU_BUBBLE: pc_wen=ifid_wen=0; idex_wen=1, idex_flush=1; exmem/memwb wen=1; next=LU_BUBBLE.
  5 !ihit: pc_wen=0; ifid_wen=1, ifid_flush=1; others wen=1; next=RUN.
  6 else: all wen=1, flush=0; next=RUN.
- LU_BUBBLE lasts one cycle; hazard detection masked there (guarantees exactly one bubble per load-use pair).
- DWAIT exits on dhit through the same table (dhit cycle advances normally, rule 5/6 apply).
- mem_op & dhit same cycle as branch_taken: rule 3 wins (mutually exclusive in legal code, priority still defined).
- HALTED: all wen=0, all flush=0, halted=1; exit only via RST.
- RST mid-DWAIT or mid-LU_BUBBLE: immediate return to RUN, outputs to reset values.

Optional Feature:
PERF_CNT_EN: adds output stall_cycles [CNT_W-1:0]; increments every cycle pc_wen=0 outside HALTED and RST, saturates at all-ones, cleared by RST. Without the macro the port and counter are absent; all other behaviour identical.

Test Plan:
- Reset: RST=1 mid-DWAIT -> state_o=0, all wen/flush=0 same cycle; release with ihit=1 -> all wen=1.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 -> 1 cycle pc_wen=0, ifid_wen=0, idex_flush=1, state_o=1; next cycle all wen=1; idex_rt=0 case -> no stall.
- Dmem wait: exmem_memread=1, dhit low 3 cycles -> 3 cycles pc/ifid/idex/exmem wen=0, memwb_flush=1, state_o=2; dhit=1 -> all advance, state_o=0.
- Branch: branch_taken=1 with lu_hazard also true -> ifid/idex/exmem flush=1, pc_wen=1, no LU_BUBBLE.
- Fetch miss: ihit=0 -> pc_wen=0, ifid_flush=1, idex..memwb wen=1.
- Halt: wb_halt=1 -> halted=1, all wen=0 persistent despite ihit/dhit toggling; PERF_CNT_EN build: 4 stall cycles -> stall_cycles=4, not incremented in HALTED.
